// File: rtl/andor_sweep_ctrl.sv
// Sweep sequencer for an external 4-input AND-OR unit: drives all 16 vectors, captures Y,
// compares against EXPECTED. Optional error log (fail_seen/first_fail) under ANDOR_ERRLOG_EN.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for start; results from the last sweep held
// ST_DRIVE  | present vector idx on a..d, load settle down-counter
// ST_WAIT   | settle down-counter running, SAMPLE at terminal count 1
// ST_SAMPLE | capture y into truth[idx], count mismatch, advance idx
// ST_DONE   | done pulse, release a..d and busy
module andor_sweep_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter logic [15:0] EXPECTED      = 16'hF888
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    input  logic        y,
    output logic        busy,
    output logic        done,
    output logic [15:0] truth,
    output logic [4:0]  err_cnt,
    output logic        pass
`ifdef ANDOR_ERRLOG_EN
    ,
    output logic        fail_seen,
    output logic [3:0]  first_fail
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_WAIT,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [3:0]  settle_q, settle_d;
    logic [3:0]  vec_q, vec_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [15:0] truth_q, truth_d;
    logic [4:0]  err_cnt_q, err_cnt_d;
    logic        pass_q, pass_d;
`ifdef ANDOR_ERRLOG_EN
    logic        fail_seen_q, fail_seen_d;
    logic [3:0]  first_fail_q, first_fail_d;
`endif

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        settle_d  = settle_q;
        vec_d     = vec_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        truth_d   = truth_q;
        err_cnt_d = err_cnt_q;
        pass_d    = pass_q;
`ifdef ANDOR_ERRLOG_EN
        fail_seen_d  = fail_seen_q;
        first_fail_d = first_fail_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_DRIVE;
                    idx_d     = 4'd0;
                    truth_d   = 16'd0;
                    err_cnt_d = 5'd0;
                    pass_d    = 1'b0;
                    busy_d    = 1'b1;
`ifdef ANDOR_ERRLOG_EN
                    fail_seen_d  = 1'b0;
                    first_fail_d = 4'd0;
`endif
                end
            end
            ST_DRIVE: begin
                vec_d    = idx_q;
                settle_d = SETTLE_INIT;
                state_d  = (SETTLE_CYCLES == 0) ? ST_SAMPLE : ST_WAIT;
            end
            ST_WAIT: begin
                settle_d = settle_q - 4'd1;
                if (settle_q == 4'd1) begin
                    state_d = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                truth_d[idx_q] = y;
                if (y != EXPECTED[idx_q]) begin
                    err_cnt_d = err_cnt_q + 5'd1;
`ifdef ANDOR_ERRLOG_EN
                    if (!fail_seen_q) begin
                        fail_seen_d  = 1'b1;
                        first_fail_d = idx_q;
                    end
`endif
                end
                if (idx_q == 4'd15) begin
                    // pass is resolved here so it is already valid while done is high
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    pass_d  = (err_cnt_d == 5'd0);
                end else begin
                    idx_d   = idx_q + 4'd1;
                    state_d = ST_DRIVE;
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                vec_d   = 4'd0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= 4'd0;
            settle_q  <= 4'd0;
            vec_q     <= 4'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            truth_q   <= 16'd0;
            err_cnt_q <= 5'd0;
            pass_q    <= 1'b0;
`ifdef ANDOR_ERRLOG_EN
            fail_seen_q  <= 1'b0;
            first_fail_q <= 4'd0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            settle_q  <= settle_d;
            vec_q     <= vec_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            truth_q   <= truth_d;
            err_cnt_q <= err_cnt_d;
            pass_q    <= pass_d;
`ifdef ANDOR_ERRLOG_EN
            fail_seen_q  <= fail_seen_d;
            first_fail_q <= first_fail_d;
`endif
        end
    end

    assign a       = vec_q[3];
    assign b       = vec_q[2];
    assign c       = vec_q[1];
    assign d       = vec_q[0];
    assign busy    = busy_q;
    assign done    = done_q;
    assign truth   = truth_q;
    assign err_cnt = err_cnt_q;
    assign pass    = pass_q;
`ifdef ANDOR_ERRLOG_EN
    assign fail_seen  = fail_seen_q;
    assign first_fail = first_fail_q;
`endif

endmodule

// File: tb/tb_andor_sweep_ctrl.sv
// Bench for andor_sweep_ctrl: two instances (SETTLE_CYCLES 0 and 1) driving a table-defined
// AND-OR unit model; results predicted from the table alone (truth = table, errors = popcount).
module tb_andor_sweep_ctrl;

    localparam logic [15:0] EXP = 16'hF888;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_v [2];
    logic        y_v     [2];
    logic        a_v     [2];
    logic        b_v     [2];
    logic        c_v     [2];
    logic        d_v     [2];
    logic        busy_v  [2];
    logic        done_v  [2];
    logic        pass_v  [2];
    logic [15:0] truth_v [2];
    logic [4:0]  err_v   [2];
`ifdef ANDOR_ERRLOG_EN
    logic        fs_v    [2];
    logic [3:0]  ff_v    [2];
`endif
    logic [15:0] tbl     [2];

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // External unit: y is whatever the table says for the vector currently driven
    assign y_v[0] = tbl[0][{a_v[0], b_v[0], c_v[0], d_v[0]}];
    assign y_v[1] = tbl[1][{a_v[1], b_v[1], c_v[1], d_v[1]}];

    andor_sweep_ctrl #(.SETTLE_CYCLES(0), .EXPECTED(EXP)) u_s0 (
        .clk(clk), .rst(rst), .start(start_v[0]),
        .a(a_v[0]), .b(b_v[0]), .c(c_v[0]), .d(d_v[0]), .y(y_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .truth(truth_v[0]),
        .err_cnt(err_v[0]), .pass(pass_v[0])
`ifdef ANDOR_ERRLOG_EN
        , .fail_seen(fs_v[0]), .first_fail(ff_v[0])
`endif
    );

    andor_sweep_ctrl #(.SETTLE_CYCLES(1), .EXPECTED(EXP)) u_s1 (
        .clk(clk), .rst(rst), .start(start_v[1]),
        .a(a_v[1]), .b(b_v[1]), .c(c_v[1]), .d(d_v[1]), .y(y_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .truth(truth_v[1]),
        .err_cnt(err_v[1]), .pass(pass_v[1])
`ifdef ANDOR_ERRLOG_EN
        , .fail_seen(fs_v[1]), .first_fail(ff_v[1])
`endif
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic int lowest_set(input logic [15:0] m);
        for (int i = 0; i < 16; i++) if (m[i]) return i;
        return 0;
    endfunction

    function automatic int sweep_latency(input int u);
        return 16 * (2 + ((u == 1) ? 1 : 0)) + 1;
    endfunction

    task automatic check_cleared(input int u);
        chk("rst_busy",  busy_v[u], 0);
        chk("rst_done",  done_v[u], 0);
        chk("rst_pass",  pass_v[u], 0);
        chk("rst_truth", truth_v[u], 0);
        chk("rst_err",   err_v[u], 0);
        chk("rst_vec",   {a_v[u], b_v[u], c_v[u], d_v[u]}, 0);
`ifdef ANDOR_ERRLOG_EN
        chk("rst_fail_seen",  fs_v[u], 0);
        chk("rst_first_fail", ff_v[u], 0);
`endif
    endtask

    task automatic check_results(input int u, input logic [15:0] t);
        logic [15:0] m;
        m = t ^ EXP;
        chk("truth",     truth_v[u], t);
        chk("err_cnt",   err_v[u], $countones(m));
        chk("pass",      pass_v[u], (m == 16'd0));
        chk("busy_idle", busy_v[u], 0);
        chk("vec_idle",  {a_v[u], b_v[u], c_v[u], d_v[u]}, 0);
`ifdef ANDOR_ERRLOG_EN
        chk("fail_seen",  fs_v[u], (m != 16'd0));
        chk("first_fail", ff_v[u], (m != 16'd0) ? lowest_set(m) : 0);
`endif
    endtask

    // One sweep on instance u with unit table t; poke_at >= 1 pulses start mid-sweep
    task automatic run_sweep(input int u, input logic [15:0] t, input int poke_at);
        int lat, n, done_at, nbad, pos;
        logic [3:0] vec, last;
        lat = sweep_latency(u);
        tbl[u] = t;
        @(negedge clk);
        start_v[u] = 1'b1;
        @(negedge clk);
        start_v[u] = 1'b0;
        n = 1;
        chk("busy_after_accept", busy_v[u], 1);
        done_at = 0;
        nbad = 0;
        pos = 0;
        last = 4'd0;
        while (done_at == 0 && n <= lat + 10) begin
            vec = {a_v[u], b_v[u], c_v[u], d_v[u]};
            if (vec != last) begin
                if (vec != 4'(pos + 1)) nbad++;
                pos++;
                last = vec;
            end
            if (done_v[u]) begin
                done_at = n;
            end else begin
                start_v[u] = (n == poke_at);
                @(negedge clk);
                n++;
            end
        end
        start_v[u] = 1'b0;
        chk("latency", done_at, lat);
        chk("vec_order_bad", nbad, 0);
        chk("vec_steps", pos, 15);
        @(negedge clk);
        chk("done_single", done_v[u], 0);
        check_results(u, t);
    endtask

    initial begin
        int n, first_done, second_done, u, lat, poke;
        logic [15:0] t;

        rst = 1'b1;
        start_v[0] = 1'b0;
        start_v[1] = 1'b0;
        tbl[0] = EXP;
        tbl[1] = EXP;
        repeat (2) @(negedge clk);
        check_cleared(0);
        check_cleared(1);
        rst = 1'b0;

        run_sweep(1, EXP, -1);
        run_sweep(1, 16'h0000, -1);
        run_sweep(1, EXP, 20);
        run_sweep(0, EXP, -1);
        run_sweep(0, 16'hFFFF, 5);

        // Reset while vector 8 is being held (S=1: vector 8 spans cycles 25..27)
        tbl[1] = EXP;
        @(negedge clk);
        start_v[1] = 1'b1;
        @(negedge clk);
        start_v[1] = 1'b0;
        repeat (25) @(negedge clk);
        chk("vec8_before_rst", {a_v[1], b_v[1], c_v[1], d_v[1]}, 8);
        rst = 1'b1;
        @(negedge clk);
        check_cleared(1);
        rst = 1'b0;
        run_sweep(1, EXP, -1);

        // start held high: next sweep is accepted in the IDLE cycle after DONE
        tbl[0] = EXP;
        @(negedge clk);
        start_v[0] = 1'b1;
        n = 0;
        first_done = 0;
        second_done = 0;
        while (second_done == 0 && n < 100) begin
            @(negedge clk);
            n++;
            if (done_v[0]) begin
                if (first_done == 0) first_done = n;
                else second_done = n;
            end
        end
        start_v[0] = 1'b0;
        chk("b2b_first_done", first_done, 33);
        chk("b2b_second_done", second_done, 67);
        @(negedge clk);
        check_results(0, EXP);

        for (int k = 0; k < 20; k++) begin
            u = int'($urandom_range(0, 1));
            t = 16'($urandom);
            if (k % 4 == 0) t = EXP;
            lat = sweep_latency(u);
            poke = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, lat - 2)) : -1;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_sweep(u, t, poke);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
